// File: rtl/aw_write_arbiter_2_1_if.sv
// rtl/aw_write_arbiter_2_1_if.sv - AW/W/B handshake bundle between the interconnect and the write arbiter
//
// Purpose: groups the per-port AW request/ready pairs, the muxed W/B
// handshake observation signals and the arbiter outputs into one bundle.
// Ports (signals):
//   S00_AXI_awvalid, S01_AXI_awvalid : write-address requests from S00/S01
//   S00_AXI_awready, S01_AXI_awready : AWREADY returned to S00/S01
//   M_AXI_awready                    : AWREADY from the addressed slave
//   M_AXI_wvalid, M_AXI_wready       : muxed W handshake
//   M_AXI_wlast                      : muxed WLAST
//   M_AXI_bvalid, M_AXI_bready       : B handshake
//   Selected_Slave                   : mux select (0 = S00, 1 = S01)
//   Write_Busy                       : grant active, enables W/B routing
// Modports: slave = arbiter side, master = interconnect/environment side.

interface aw_write_arbiter_2_1_if;
  logic S00_AXI_awvalid;
  logic S01_AXI_awvalid;
  logic S00_AXI_awready;
  logic S01_AXI_awready;
  logic M_AXI_awready;
  logic M_AXI_wvalid;
  logic M_AXI_wready;
  logic M_AXI_wlast;
  logic M_AXI_bvalid;
  logic M_AXI_bready;
  logic Selected_Slave;
  logic Write_Busy;

  modport slave (
    input  S00_AXI_awvalid,
    input  S01_AXI_awvalid,
    input  M_AXI_awready,
    input  M_AXI_wvalid,
    input  M_AXI_wready,
    input  M_AXI_wlast,
    input  M_AXI_bvalid,
    input  M_AXI_bready,
    output S00_AXI_awready,
    output S01_AXI_awready,
    output Selected_Slave,
    output Write_Busy
  );

  modport master (
    output S00_AXI_awvalid,
    output S01_AXI_awvalid,
    output M_AXI_awready,
    output M_AXI_wvalid,
    output M_AXI_wready,
    output M_AXI_wlast,
    output M_AXI_bvalid,
    output M_AXI_bready,
    input  S00_AXI_awready,
    input  S01_AXI_awready,
    input  Selected_Slave,
    input  Write_Busy
  );
endinterface

// File: rtl/aw_write_arbiter_2_1.sv
// rtl/aw_write_arbiter_2_1.sv - 2:1 write-path arbiter holding the grant for a whole AW/W/B transaction
//
// Purpose: picks S00 or S01 for the downstream write-address mux, returns
// AWREADY only to the granted port and keeps the grant until the B handshake
// so that W and B routing stay aligned with the granted AW.
// Parameters:
//   Fixed_Priority : 0 = round-robin on ties, 1 = S00 always wins ties
// Ports:
//   ACLK    : clock, all state on rising edge
//   ARESETN : asynchronous active-low reset
//   bus     : aw_write_arbiter_2_1_if.slave (requests, handshakes, select, busy)

module aw_write_arbiter_2_1 #(
  parameter bit Fixed_Priority = 1'b0
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  aw_write_arbiter_2_1_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  logic   sel_q;
  logic   busy_q;
  logic   w_done;
  logic   last_grant;

  logic   sel_awvalid;
  logic   aw_hs;
  logic   wlast_hs;
  logic   b_hs;
  logic   any_req;
  logic   pick;

  // awvalid of whichever port currently owns the mux
  assign sel_awvalid = sel_q ? bus.S01_AXI_awvalid : bus.S00_AXI_awvalid;

  assign aw_hs    = sel_awvalid & bus.M_AXI_awready;
  assign wlast_hs = bus.M_AXI_wvalid & bus.M_AXI_wready & bus.M_AXI_wlast;
  assign b_hs     = bus.M_AXI_bvalid & bus.M_AXI_bready;
  assign any_req  = bus.S00_AXI_awvalid | bus.S01_AXI_awvalid;

  // Tie-break: fixed mode favours S00; round-robin favours the port that
  // did not win last time (last_grant resets to 1 so S00 goes first).
  always_comb begin
    pick = 1'b0;
    if (bus.S00_AXI_awvalid && bus.S01_AXI_awvalid) begin
      pick = Fixed_Priority ? 1'b0 : ~last_grant;
    end else if (bus.S01_AXI_awvalid) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      w_done     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // W traffic seen here belongs to nobody and must not count
          w_done <= 1'b0;
          if (any_req) begin
            sel_q  <= pick;
            busy_q <= 1'b1;
            state  <= ADDR;
          end
        end

        ADDR: begin
          // W may legally complete before AW; remember it so DATA is skipped
          if (wlast_hs) begin
            w_done <= 1'b1;
          end
          if (aw_hs) begin
            state <= (w_done || wlast_hs) ? RESP : DATA;
          end
        end

        DATA: begin
          if (wlast_hs) begin
            state <= RESP;
          end
        end

        RESP: begin
          if (b_hs) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            last_grant <= sel_q;
            w_done     <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          w_done <= 1'b0;
        end
      endcase
    end
  end

  // AWREADY is a pass-through gated by the grant; the loser always sees 0
  assign bus.S00_AXI_awready = (state == ADDR) & ~sel_q & bus.M_AXI_awready;
  assign bus.S01_AXI_awready = (state == ADDR) &  sel_q & bus.M_AXI_awready;

  assign bus.Selected_Slave = sel_q;
  assign bus.Write_Busy     = busy_q;

endmodule

// File: tb/tb_aw_write_arbiter_2_1.sv
// tb/tb_aw_write_arbiter_2_1.sv - self-checking bench for aw_write_arbiter_2_1 (round-robin and fixed-priority)

module tb_aw_write_arbiter_2_1;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;

  always #5 ACLK = ~ACLK;

  logic s00v, s01v, awr, wv, wr, wl, bv, br;

  aw_write_arbiter_2_1_if if0 ();
  aw_write_arbiter_2_1_if if1 ();

  assign if0.S00_AXI_awvalid = s00v;
  assign if0.S01_AXI_awvalid = s01v;
  assign if0.M_AXI_awready   = awr;
  assign if0.M_AXI_wvalid    = wv;
  assign if0.M_AXI_wready    = wr;
  assign if0.M_AXI_wlast     = wl;
  assign if0.M_AXI_bvalid    = bv;
  assign if0.M_AXI_bready    = br;

  assign if1.S00_AXI_awvalid = s00v;
  assign if1.S01_AXI_awvalid = s01v;
  assign if1.M_AXI_awready   = awr;
  assign if1.M_AXI_wvalid    = wv;
  assign if1.M_AXI_wready    = wr;
  assign if1.M_AXI_wlast     = wl;
  assign if1.M_AXI_bvalid    = bv;
  assign if1.M_AXI_bready    = br;

  aw_write_arbiter_2_1 #(.Fixed_Priority(1'b0)) u_rr (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (if0)
  );

  aw_write_arbiter_2_1 #(.Fixed_Priority(1'b1)) u_fp (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (if1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected grant order per instance, consumed on each rising Write_Busy
  bit q_rr[$];
  bit q_fp[$];
  logic pb_rr = 1'b0;
  logic pb_fp = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ACLK) begin
    if (if0.Write_Busy === 1'b1 && pb_rr !== 1'b1) begin
      if (q_rr.size() == 0) begin
        cmp("rr_unexpected_grant", 32'(if0.Selected_Slave), 32'hdead);
      end else begin
        cmp("rr_grant_order", 32'(if0.Selected_Slave), 32'(q_rr.pop_front()));
      end
    end
    if (if1.Write_Busy === 1'b1 && pb_fp !== 1'b1) begin
      if (q_fp.size() == 0) begin
        cmp("fp_unexpected_grant", 32'(if1.Selected_Slave), 32'hdead);
      end else begin
        cmp("fp_grant_order", 32'(if1.Selected_Slave), 32'(q_fp.pop_front()));
      end
    end
    pb_rr = if0.Write_Busy;
    pb_fp = if1.Write_Busy;
  end

  task automatic set_in(input logic a, b, c, d, e, f, g, h);
    s00v = a; s01v = b; awr = c; wv = d; wr = e; wl = f; bv = g; br = h;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic sel, busy, r0, r1);
    @(negedge ACLK);
    #1;
    cmp({name, "_sel"},  32'(if0.Selected_Slave),  32'(sel));
    cmp({name, "_busy"}, 32'(if0.Write_Busy),      32'(busy));
    cmp({name, "_r0"},   32'(if0.S00_AXI_awready), 32'(r0));
    cmp({name, "_r1"},   32'(if0.S01_AXI_awready), 32'(r1));
  endtask

  typedef struct {
    logic s00v, s01v, awr, wv, wr, wl, bv, br;
    logic sel, busy, r0, r1;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // single requester S00, then S01 with a stray wlast in IDLE beforehand
    tbl[0]  = '{1,0,0,0,0,0,0,0, 0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0,0,0, 0,1,0,0};
    tbl[2]  = '{1,0,1,0,0,0,0,0, 0,1,1,0};
    tbl[3]  = '{0,0,1,1,1,1,0,0, 0,1,0,0};
    tbl[4]  = '{0,0,0,0,0,0,0,0, 0,1,0,0};
    tbl[5]  = '{0,0,0,0,0,0,1,1, 0,1,0,0};
    tbl[6]  = '{0,0,0,0,0,0,0,0, 0,0,0,0};
    tbl[7]  = '{0,0,0,1,1,1,0,0, 0,0,0,0};
    tbl[8]  = '{0,1,0,0,0,0,0,0, 0,0,0,0};
    tbl[9]  = '{0,1,1,0,0,0,0,0, 1,1,0,1};
    tbl[10] = '{0,0,0,0,0,0,1,1, 1,1,0,0};
    tbl[11] = '{0,0,0,1,1,1,0,0, 1,1,0,0};
    tbl[12] = '{0,0,0,0,0,0,1,1, 1,1,0,0};
    tbl[13] = '{0,0,0,0,0,0,0,0, 1,0,0,0};

    set_in(0,0,1,0,0,0,0,0);
    tick();
    chk("reset", 0, 0, 0, 0);
    tick();
    ARESETN = 1'b1;

    // Table-driven single-requester sequence
    q_rr.push_back(0); q_rr.push_back(1);
    q_fp.push_back(0); q_fp.push_back(1);
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].s00v, tbl[i].s01v, tbl[i].awr, tbl[i].wv,
             tbl[i].wr, tbl[i].wl, tbl[i].bv, tbl[i].br);
      chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].busy, tbl[i].r0, tbl[i].r1);
      tick();
    end

    // Both ports requesting for three back-to-back transactions
    // (last_grant is S01 here, so round-robin restarts at S00)
    q_rr.push_back(0); q_rr.push_back(1); q_rr.push_back(0);
    q_fp.push_back(0); q_fp.push_back(0); q_fp.push_back(0);
    set_in(1,1,1,1,1,1,1,1);
    for (int i = 0; i < 9; i++) tick();
    set_in(0,0,0,0,0,0,0,0);
    @(negedge ACLK);
    cmp("contend_rr_idle", 32'(if0.Write_Busy), 32'd0);
    cmp("contend_fp_idle", 32'(if1.Write_Busy), 32'd0);
    tick();

    // W last before AW: ADDR -> RESP with no DATA in between
    q_rr.push_back(0); q_fp.push_back(0);
    set_in(1,0,0,0,0,0,0,0); chk("wfirst_idle", 0, 0, 0, 0); tick();
    set_in(1,0,0,1,1,1,0,0); chk("wfirst_addr_w", 0, 1, 0, 0); tick();
    set_in(1,0,0,0,0,0,0,0); chk("wfirst_addr_wait", 0, 1, 0, 0); tick();
    set_in(1,0,1,0,0,0,0,0); chk("wfirst_addr_aw", 0, 1, 1, 0); tick();
    set_in(0,0,0,0,0,0,1,1); chk("wfirst_resp", 0, 1, 0, 0); tick();
    set_in(0,0,0,0,0,0,0,0); chk("wfirst_done", 0, 0, 0, 0); tick();

    // AW and W last in the same cycle
    q_rr.push_back(1); q_fp.push_back(1);
    set_in(0,1,0,0,0,0,0,0); chk("same_idle", 0, 0, 0, 0); tick();
    set_in(0,1,1,1,1,1,0,0); chk("same_addr", 1, 1, 0, 1); tick();
    set_in(0,0,0,0,0,0,1,1); chk("same_resp", 1, 1, 0, 0); tick();
    set_in(0,0,0,0,0,0,0,0); chk("same_done", 1, 0, 0, 0); tick();

    // B backpressure with a pending S01 request
    q_rr.push_back(0); q_fp.push_back(0);
    q_rr.push_back(1); q_fp.push_back(1);
    set_in(1,0,0,0,0,0,0,0); chk("bp_idle", 1, 0, 0, 0); tick();
    set_in(1,0,1,1,1,1,0,0); chk("bp_addr", 0, 1, 1, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0,1,0,0,0,0,1,0);
      chk($sformatf("bp_hold%0d", i), 0, 1, 0, 0);
      tick();
    end
    set_in(0,1,0,0,0,0,1,1); chk("bp_release", 0, 1, 0, 0); tick();
    set_in(0,1,0,0,0,0,0,0); chk("bp_idle_gap", 0, 0, 0, 0); tick();
    set_in(0,1,1,1,1,1,0,0); chk("bp_s01_addr", 1, 1, 0, 1); tick();
    set_in(0,0,0,0,0,0,1,1); chk("bp_s01_resp", 1, 1, 0, 0); tick();
    set_in(0,0,0,0,0,0,0,0); chk("bp_s01_done", 1, 0, 0, 0); tick();

    // Asynchronous reset in the middle of DATA on an S01 grant
    q_rr.push_back(1); q_fp.push_back(1);
    set_in(0,1,0,0,0,0,0,0); chk("ar_idle", 1, 0, 0, 0); tick();
    set_in(0,1,1,0,0,0,0,0); chk("ar_addr", 1, 1, 0, 1); tick();
    set_in(0,0,1,0,0,0,0,0); chk("ar_data", 1, 1, 0, 0);
    ARESETN = 1'b0;
    #1;
    cmp("ar_now_busy", 32'(if0.Write_Busy),      32'd0);
    cmp("ar_now_sel",  32'(if0.Selected_Slave),  32'd0);
    cmp("ar_now_r0",   32'(if0.S00_AXI_awready), 32'd0);
    cmp("ar_now_r1",   32'(if0.S01_AXI_awready), 32'd0);
    cmp("ar_now_fp_busy", 32'(if1.Write_Busy),   32'd0);
    set_in(1,1,0,0,0,0,0,0);
    tick();
    tick();
    ARESETN = 1'b1;
    q_rr.push_back(0); q_fp.push_back(0);
    chk("ar_post_idle", 0, 0, 0, 0); tick();
    set_in(1,1,1,1,1,1,0,0); chk("ar_post_addr", 0, 1, 1, 0); tick();
    set_in(0,0,0,0,0,0,1,1); chk("ar_post_resp", 0, 1, 0, 0); tick();
    set_in(0,0,0,0,0,0,0,0); chk("ar_post_done", 0, 0, 0, 0); tick();

    cmp("rr_queue_empty", 32'(q_rr.size()), 32'd0);
    cmp("fp_queue_empty", 32'(q_fp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
